// File: rtl/sram_arbiter.sv
// Two-port arbiter in front of a single SRAM controller command port.
// Grants one access per cycle, registers the command, and routes read data back via a tag FIFO.
module sram_arbiter #(
  parameter int ADDR_W          = 18,
  parameter int DATA_W          = 16,
  parameter int MAX_OUTSTANDING = 4,
  parameter bit FIXED_PRIORITY  = 1'b0
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [1:0]        i_reqValid,
  input  logic [1:0]        i_reqRnW,
  input  logic [ADDR_W-1:0] i_req0Addr,
  input  logic [DATA_W-1:0] i_req0Wdata,
  input  logic [ADDR_W-1:0] i_req1Addr,
  input  logic [DATA_W-1:0] i_req1Wdata,
  output logic [1:0]        o_reqReady,
  output logic [DATA_W-1:0] o_rdata,
  output logic [1:0]        o_rdataValid,
  output logic              o_sramStart,
  output logic              o_sramRnW,
  output logic [ADDR_W-1:0] o_sramAddr,
  output logic [DATA_W-1:0] o_sramWdata,
  input  logic              i_sramReady,
  input  logic [DATA_W-1:0] i_sramRdata,
  input  logic              i_sramRdataValid,
  output logic              o_error
);

  localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

  // Valid/ready: port n's request is accepted in the cycle where i_reqValid[n] && o_reqReady[n];
  // the requester keeps valid and payload stable until then, and ready never waits on a later cycle.

  logic             tag_mem [MAX_OUTSTANDING];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             last_grant;
  logic             fifo_full;
  logic             pop;
  logic             push;
  logic             sel;
  logic [1:0]       eligible;
  logic [1:0]       grant;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign fifo_full = (count == CNT_W'(MAX_OUTSTANDING));
  assign pop       = i_sramRdataValid && (count != '0);

  // A pop in this cycle frees a slot, so a read may be granted against a full FIFO.
  assign eligible[0] = !i_reset && i_sramReady && i_reqValid[0] &&
                       (!i_reqRnW[0] || !fifo_full || pop);
  assign eligible[1] = !i_reset && i_sramReady && i_reqValid[1] &&
                       (!i_reqRnW[1] || !fifo_full || pop);

  always_comb begin
    grant = 2'b00;
    if (eligible == 2'b11) begin
      grant = (FIXED_PRIORITY || last_grant) ? 2'b01 : 2'b10;
    end else begin
      grant = eligible;
    end
  end

  assign sel        = grant[1];
  assign push       = (|grant) && i_reqRnW[sel];
  assign o_reqReady = grant;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_sramStart  <= 1'b0;
      o_sramRnW    <= 1'b1;
      o_sramAddr   <= '0;
      o_sramWdata  <= '0;
      o_rdata      <= '0;
      o_rdataValid <= 2'b00;
      o_error      <= 1'b0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      last_grant   <= 1'b1;
    end else begin
      if (|grant) begin
        o_sramStart <= 1'b1;
        o_sramRnW   <= i_reqRnW[sel];
        o_sramAddr  <= sel ? i_req1Addr : i_req0Addr;
        o_sramWdata <= sel ? i_req1Wdata : i_req0Wdata;
        last_grant  <= sel;
      end else begin
        o_sramStart <= 1'b0;
        o_sramRnW   <= 1'b1;
      end

      if (push) begin
        tag_mem[wr_ptr] <= sel;
        wr_ptr          <= ptr_next(wr_ptr);
      end

      o_rdataValid <= 2'b00;
      if (pop) begin
        o_rdata      <= i_sramRdata;
        o_rdataValid <= tag_mem[rd_ptr] ? 2'b10 : 2'b01;
        rd_ptr       <= ptr_next(rd_ptr);
      end else if (i_sramRdataValid) begin
        o_error <= 1'b1;
      end

      if (push && !pop) begin
        count <= count + CNT_W'(1);
      end else if (!push && pop) begin
        count <= count - CNT_W'(1);
      end
    end
  end

endmodule
